// File: rtl/alu_datapath.sv
// alu_datapath: 8-bit ALU datapath (add/sub, Booth multiply, non-restoring divide) driven by a one-hot control word
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      c,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             q_0,
  output logic             q_min1,
  output logic             sign,
  output logic             cnt7,
  output logic [WIDTH-1:0] out_bus,
  output logic             out_valid,
  output logic             ovf
);
  localparam int CW = WIDTH > 2 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {M_ADDSUB, M_MUL, M_DIV} mode_t;
  mode_t r_mode, w_mode;
  logic [WIDTH:0] r_a, r_m, w_a, w_m, w_sum;
  logic [WIDTH-1:0] r_q, w_q, r_out;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic r_qm1, w_qm1, r_valid, r_ovf, w_last, w_c8_sh, w_init;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_c8_sh = c[8] & ~w_last;
  assign w_init = |c[2:0];
  assign w_sum = c[5] ? r_a - r_m : r_a + r_m;
  assign w_cnt_inc = w_last ? '0 : r_cnt + 1'b1;
  assign q_0 = r_q[0];
  assign q_min1 = r_qm1;
  assign sign = r_a[WIDTH];
  assign cnt7 = w_last;
  assign out_bus = r_out;
  assign out_valid = r_valid;
  assign ovf = r_ovf;
  always_comb begin
    w_a = r_a;
    w_q = r_q;
    w_qm1 = r_qm1;
    w_m = r_m;
    w_mode = r_mode;
    w_cnt = r_cnt;
    if (c[0]) begin
      w_a = {x_in[WIDTH-1], x_in};
      w_m = {y_in[WIDTH-1], y_in};
      w_q = '0;
      w_qm1 = 1'b0;
      w_cnt = '0;
      w_mode = M_ADDSUB;
    end else if (c[1]) begin
      w_a = '0;
      w_q = x_in;
      w_qm1 = 1'b0;
      w_m = {y_in[WIDTH-1], y_in};
      w_cnt = '0;
      w_mode = M_MUL;
    end else if (c[2]) begin
      w_a = '0;
      w_q = x_in;
      w_m = {1'b0, y_in};
      w_cnt = '0;
      w_mode = M_DIV;
    end else begin
      if (c[3]) begin
        if (r_mode == M_DIV) {w_a, w_q} = {r_a[WIDTH-1:0], r_q, 1'b0};
      end else if (c[4]) begin
        w_a = w_sum;
      end else if (c[6]) begin
        w_q[0] = ~r_a[WIDTH];
      end else if (c[7]) begin
        w_a = {r_a[WIDTH], r_a[WIDTH:1]};
        w_q = {r_a[0], r_q[WIDTH-1:1]};
        w_qm1 = r_q[0];
      end else if (w_c8_sh) begin
        {w_a, w_q} = {r_a[WIDTH-1:0], r_q, 1'b0};
      end else if (c[10]) begin
        w_a = r_a + r_m;
      end
      w_cnt = c[3] ? '0 : (c[8] | c[9]) ? w_cnt_inc : r_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_m <= '0;
      r_q <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
      r_mode <= M_ADDSUB;
    end else begin
      r_a <= w_a;
      r_m <= w_m;
      r_q <= w_q;
      r_qm1 <= w_qm1;
      r_cnt <= w_cnt;
      r_mode <= w_mode;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_valid <= ~w_init & (c[11] | c[12]);
      if (!w_init && c[12]) begin
        r_out <= r_a[WIDTH-1:0];
      end else if (!w_init && c[11]) begin
        r_out <= r_mode == M_ADDSUB ? r_a[WIDTH-1:0] : r_q;
        r_ovf <= r_mode == M_ADDSUB && (r_a[WIDTH] ^ r_a[WIDTH-1]);
      end
    end
  end
endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- 8-bit ALU datapath that executes the 13-bit one-hot control word `c[12:0]` issued by the ALU control unit each cycle.
- Holds accumulator A, multiplicand/divisor M, register Q, Booth bit Q-1 and iteration counter CNT. Returns the status bits `q_0`, `q_min1`, `sign` and `cnt7` to the control unit.
- Supports signed add/sub, signed Booth multiply (8x8→16) and unsigned non-restoring divide (8/8 → quotient, remainder).
- Results leave on an 8-bit output bus, one byte per `c11`/`c12` strobe.

Parameters:
WIDTH, 8, operand width. A and M are WIDTH+1 bits; CNT is clog2(WIDTH) bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
c  input  13  control word from control unit
x_in  input  WIDTH  operand X (addend / multiplier / dividend)
y_in  input  WIDTH  operand Y (addend / multiplicand / divisor)
q_0  output  1  Q[0], combinational from register
q_min1  output  1  Booth bit Q-1, combinational from register
sign  output  1  A[WIDTH] (sign of A), combinational from register
cnt7  output  1  CNT == WIDTH-1, combinational from register
out_bus  output  WIDTH  registered result byte
out_valid  output  1  one-cycle pulse, out_bus valid
ovf  output  1  registered signed-overflow flag for add/sub

Behaviour:
- Clock and reset: single clock, `clk`. Reset is synchronous and active-high on `rst`.
- On `rst`: A, M, Q, Q-1, CNT and mode all clear to 0; `out_bus`=0, `out_valid`=0, `ovf`=0. Reset mid-operation aborts with no residual state.
- All register updates happen on the `clk` edge where the corresponding control bit is high. Status outputs reflect the register values of the current cycle.
- Control bit actions:
  - `c0`, init add/sub: A←sext(x_in); M←sext(y_in); Q←0; Q-1←0; CNT←0; mode←ADDSUB.
  - `c1`, init multiply: A←0; Q←x_in; Q-1←0; M←sext(y_in); CNT←0; mode←MUL.
  - `c2`, init divide: A←0; Q←x_in; M←zext(y_in); CNT←0; mode←DIV.
  - `c3`, prepare: CNT←0. If mode=DIV, also {A,Q} shift left by 1 (Q[0]←0).
  - `c4`, arithmetic: A←A+M, or A←A−M when `c5`=1. Width WIDTH+1, modulo 2^(WIDTH+1). `c5` without `c4` has no effect.
  - `c6`, quotient bit: Q[0]←~A[WIDTH].
  - `c7`, Booth shift: arithmetic right shift of {A,Q,Q-1}. A[WIDTH] is kept; Q[WIDTH-1]←A[0]; Q-1←Q[0].
  - `c8`, divide step: CNT←CNT+1. If CNT≠WIDTH-1, also {A,Q} shift left by 1. This gives WIDTH shifts in total including `c3`.
  - `c9`, multiply step: CNT←CNT+1.
  - `c10`, remainder correction: A←A+M.
  - `c11`, output low byte:
    - mode=ADDSUB: out_bus←A[WIDTH-1:0]; ovf←A[WIDTH]^A[WIDTH-1].
    - otherwise: out_bus←Q; ovf←0.
    - In all modes `out_valid` is 1 in the next cycle.
  - `c12`, output high byte: out_bus←A[WIDTH-1:0]; `out_valid` is 1 in the next cycle. `ovf` is unchanged.
- Counter: CNT wraps WIDTH-1→0.
- `out_valid` deasserts after one cycle unless `c11`/`c12` is asserted again. `out_bus` holds its value between strobes.
- Simultaneous bits:
  - Any of `c0`–`c2` overrides every other bit; if several are high, the lowest index wins.
  - Among the A/Q writers {`c3`,`c4`,`c6`,`c7`,`c8`-shift,`c10`}, the lowest index wins.
  - CNT updates (`c3`/`c8`/`c9`) and output strobes act independently. `c3` beats `c8`/`c9` on CNT.
  - `c11` and `c12` together: `c12` wins.
- `c`=0: all registers hold.
- Results: product = {A[WIDTH-1:0],Q} signed; quotient = Q; remainder = A[WIDTH-1:0].
- Division by zero is not trapped: it yields Q=all ones, remainder = x_in after correction.

Test Plan:
- Add. Reset; `c0` with x=0x05, y=0x03; `c3`; `c4`; `c11` → out_bus=0x08, out_valid high exactly 1 cycle, ovf=0.
- Subtract overflow. `c0` with x=0x80, y=0x01; `c3`; `c4`+`c5`; `c11` → out_bus=0x7F, ovf=1.
- Multiply. Bench follows Booth from q_0/q_min1 with x=0xFD (−3), y=0x07 for 8 iterations (`c4`[/`c5`], `c7`, `c9`) → cnt7 high during 8th iteration; `c11` gives 0xEB, `c12` gives 0xFF (−21).
- Divide. x=100, y=7; `c3`, then 8×(`c4` with `c5`=~sign, `c6`, `c8`); `c10` iff sign → `c11` out 0x0E, `c12` out 0x02.
- Divide with correction. x=7, y=10 → sign=1 at loop end; `c10` applied; quotient 0x00, remainder 0x07.
- Reset mid-multiply. Assert `rst` at iteration 4 → next cycle q_0=q_min1=sign=cnt7=0, out_valid=0, out_bus=0; a fresh `c0` add 2+2 then gives 0x04.
